// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-master Wishbone data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned WB_ADR_W    = 32;
  localparam int unsigned WB_DAT_W    = 32;
  localparam int unsigned WB_SEL_W    = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1
  } arb_state_t;

  typedef struct packed {
    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus watchdog: counts strobe cycles without a response and flags expiry
// in the cycle the count reaches TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 disables it.
module wb_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_clear,
  output logic o_expire
);

  localparam int unsigned CW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CW-1:0] r_cnt;
  logic          w_expire;

  assign w_expire = (TIMEOUT_CYCLES != 0) && i_active && (r_cnt == CW'(LIMIT));
  assign o_expire = w_expire;

  // Saturating count; expiry clears so the master may retry without a stale count.
  always_ff @(posedge clk) begin
    if (reset || i_clear || w_expire || (TIMEOUT_CYCLES == 0)) begin
      r_cnt <= '0;
    end else if (i_active && (r_cnt != CW'(TIMEOUT_CYCLES))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_dmem_arbiter.sv
// Round-robin Wishbone classic arbiter: core data port (m0) and debug bus master (m1)
// share the data memory slave; grant is held for the whole cyc burst.
module wb_dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned PRIO_RESET     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_adr,
  input  logic [31:0]           m0_dat_i,
  input  logic [3:0]            m0_sel,
  output logic [31:0]           m0_dat_o,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_adr,
  input  logic [31:0]           m1_dat_i,
  input  logic [3:0]            m1_sel,
  output logic [31:0]           m1_dat_o,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_adr,
  output logic [31:0]           s_dat_o,
  output logic [3:0]            s_sel,
  input  logic [31:0]           s_dat_i,
  input  logic                  s_ack,
  input  logic                  s_err,
  output logic [1:0]            grant,
  output logic                  timeout_pulse
);

  arb_state_t r_state, w_next_state;
  logic       r_prio, w_next_prio;
  wb_req_t    w_req0, w_req1, w_own;
  logic       w_own0, w_own1, w_any;
  logic       w_active, w_clear, w_expire;
  logic [NUM_MASTERS-1:0] w_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_prio  <= 1'(PRIO_RESET);
    end else begin
      r_state <= w_next_state;
      r_prio  <= w_next_prio;
    end
  end

  // r_prio names the master that wins a simultaneous request from idle.
  always_comb begin
    w_next_state = r_state;
    w_next_prio  = r_prio;
    case (r_state)
      ARB_IDLE: begin
        if (m0_cyc && (!m1_cyc || !r_prio)) w_next_state = ARB_OWN0;
        else if (m1_cyc)                    w_next_state = ARB_OWN1;
      end
      ARB_OWN0: if (!m0_cyc) begin
        w_next_state = ARB_IDLE;
        w_next_prio  = 1'b1;
      end
      ARB_OWN1: if (!m1_cyc) begin
        w_next_state = ARB_IDLE;
        w_next_prio  = 1'b0;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_req0 = '{cyc: m0_cyc, stb: m0_stb, we: m0_we, adr: WB_ADR_W'(m0_adr),
               dat: m0_dat_i, sel: m0_sel};
    w_req1 = '{cyc: m1_cyc, stb: m1_stb, we: m1_we, adr: WB_ADR_W'(m1_adr),
               dat: m1_dat_i, sel: m1_sel};
    w_own0 = (r_state == ARB_OWN0);
    w_own1 = (r_state == ARB_OWN1);
    w_any  = w_own0 | w_own1;
    w_own  = '0;
    if (w_own0)      w_own = w_req0;
    else if (w_own1) w_own = w_req1;
  end

  // Watchdog sees only a live owner strobe with no slave response.
  assign w_active = w_any & w_own.cyc & w_own.stb & ~s_ack & ~s_err;
  assign w_clear  = ~w_active;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .i_active(w_active),
    .i_clear (w_clear),
    .o_expire(w_expire)
  );

  always_comb begin
    w_grant       = {w_own1, w_own0};
    grant         = w_grant;
    s_cyc         = w_own.cyc & ~w_expire;
    s_stb         = w_own.stb & ~w_expire;
    s_we          = w_own.we;
    s_adr         = ADDR_WIDTH'(w_own.adr);
    s_dat_o       = w_own.dat;
    s_sel         = w_own.sel;
    m0_dat_o      = w_own0 ? s_dat_i : '0;
    m1_dat_o      = w_own1 ? s_dat_i : '0;
    m0_ack        = w_own0 & s_ack;
    m1_ack        = w_own1 & s_ack;
    m0_err        = w_own0 & (s_err | w_expire);
    m1_err        = w_own1 & (s_err | w_expire);
    timeout_pulse = w_expire;
  end

endmodule

// File: tb/tb_wb_dmem_arbiter.sv
// Directed bench for wb_dmem_arbiter with an 8-cycle watchdog; the bench plays the slave.
module tb_wb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m1_adr, m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack, s_err;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [1:0]  grant;
  logic        timeout_pulse;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  wb_dmem_arbiter #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(8),
    .PRIO_RESET    (0)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_i(m0_dat_i), .m0_sel(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_i(m1_dat_i), .m1_sel(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o), .s_sel(s_sel),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .s_err(s_err),
    .grant(grant), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks run 1 unit later, well before negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_i = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_i = '0; m1_sel = '0;
    s_ack = 0; s_err = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  logic [31:0] wr_adr [4];
  logic [31:0] wr_dat [4];
  logic [3:0]  wr_sel [4];

  initial begin
    #100000;
    $display("FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    wr_adr = '{32'h0000_0200, 32'h0000_0204, 32'h0000_0208, 32'h0000_020C};
    wr_dat = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    wr_sel = '{4'hF, 4'h3, 4'hC, 4'h1};

    // Reset state
    do_reset();
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_m0_ack", m0_ack, 0);
    check("rst_pulse", timeout_pulse, 0);

    // m0 single read at 0x100, ack on the third owned cycle
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m0_sel = 4'hF;
    #1 check("s1_grant_same_cycle", grant, 2'b00);
    tick(); #1;
    check("s1_grant", grant, 2'b01);
    check("s1_s_cyc", s_cyc, 1);
    check("s1_s_adr", s_adr, 32'h100);
    check("s1_no_ack", m0_ack, 0);
    tick(); tick();
    s_ack = 1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    check("s1_ack", m0_ack, 1);
    check("s1_dat", m0_dat_o, 32'hDEAD_BEEF);
    check("s1_m1_dat", m1_dat_o, 32'h0);
    tick();
    s_ack = 0; s_dat_i = '0; m0_cyc = 0; m0_stb = 0;
    #1 check("s1_release_hold", grant, 2'b01);
    tick(); #1;
    check("s1_idle", grant, 2'b00);

    // Simultaneous request after reset: m0 first, m1 two edges after m0 releases
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
    tick();
    s_ack = 1; #1;
    check("s2_grant_m0", grant, 2'b01);
    check("s2_m0_ack", m0_ack, 1);
    check("s2_m1_blocked", m1_ack, 0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick(); #1;
    check("s2_gap", grant, 2'b00);
    tick();
    s_ack = 1; s_err = 1; #1;
    check("s2_grant_m1", grant, 2'b10);
    check("s2_s_adr_m1", s_adr, 32'h20);
    check("s2_m1_ack", m1_ack, 1);
    check("s2_m1_err_pass", m1_err, 1);
    check("s2_m0_err_none", m0_err, 0);
    tick();
    s_ack = 0; s_err = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();
    // m0 alone then releases: priority moves to m1
    m0_cyc = 1; m0_stb = 1;
    tick();
    s_ack = 1;
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick(); tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick(); #1;
    check("s2_rr_m1_first", grant, 2'b10);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick(); tick();

    // m1 block write of four beats while m0 waits
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
    for (int unsigned k = 0; k < 4; k++) begin
      m1_adr = wr_adr[k]; m1_dat_i = wr_dat[k]; m1_sel = wr_sel[k]; s_ack = 1;
      #1;
      check($sformatf("s3_adr%0d", k), s_adr, wr_adr[k]);
      check($sformatf("s3_dat%0d", k), s_dat_o, wr_dat[k]);
      check($sformatf("s3_sel%0d", k), s_sel, wr_sel[k]);
      check($sformatf("s3_we%0d", k), s_we, 1);
      check($sformatf("s3_m1ack%0d", k), m1_ack, 1);
      check($sformatf("s3_m0blk%0d", k), m0_ack, 0);
      check($sformatf("s3_grant%0d", k), grant, 2'b10);
      tick();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    #1 check("s3_release_hold", grant, 2'b10);
    tick(); #1;
    check("s3_gap", grant, 2'b00);
    tick(); #1;
    check("s3_m0_granted", grant, 2'b01);
    check("s3_m0_adr", s_adr, 32'h300);
    m0_cyc = 0; m0_stb = 0;
    tick(); tick();

    // Watchdog expiry on the 8th unacked strobe cycle
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
    tick();
    for (int unsigned c = 1; c < 8; c++) begin
      #1;
      check($sformatf("s4_nopulse%0d", c), timeout_pulse, 0);
      check($sformatf("s4_noerr%0d", c), m0_err, 0);
      tick();
    end
    #1;
    check("s4_err", m0_err, 1);
    check("s4_pulse", timeout_pulse, 1);
    check("s4_s_stb", s_stb, 0);
    check("s4_s_cyc", s_cyc, 0);
    check("s4_grant", grant, 2'b01);
    tick(); #1;
    check("s4_pulse_1cyc", timeout_pulse, 0);
    check("s4_grant_kept", grant, 2'b01);
    m0_cyc = 0; m0_stb = 0;
    tick(); tick(); #1;
    check("s4_idle", grant, 2'b00);

    // Ack arriving exactly in the expiry cycle wins
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int unsigned c = 1; c < 8; c++) tick();
    s_ack = 1; #1;
    check("s5_ack", m0_ack, 1);
    check("s5_no_err", m0_err, 0);
    check("s5_no_pulse", timeout_pulse, 0);
    check("s5_s_stb", s_stb, 1);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick(); tick();

    // Reset during an m1 transfer; priority left at m1 by the previous release
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h500;
    tick(); #1;
    check("s6_grant_m1", grant, 2'b10);
    reset = 1; m0_cyc = 1; m0_stb = 1; s_ack = 1;
    tick(); #1;
    check("s6_rst_grant", grant, 2'b00);
    check("s6_rst_s_cyc", s_cyc, 0);
    check("s6_rst_m0_ack", m0_ack, 0);
    check("s6_rst_m1_ack", m1_ack, 0);
    reset = 0; s_ack = 0;
    tick(); #1;
    check("s6_prio_reset", grant, 2'b01);
    idle_inputs();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
